// File: rtl/msg_pkg.sv
// Shared definitions for the message transmit path.
//   state_e         : sender FSM states
//   MSG_LEN_DEFAULT : bytes per message ("10110010\n\r")
//   ASCII_LF/CR     : line terminators that close every message
package msg_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLoad  = 3'd2,
    StHold  = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam int unsigned MSG_LEN_DEFAULT = 10;
  localparam logic [7:0]  ASCII_LF        = 8'h0A;
  localparam logic [7:0]  ASCII_CR        = 8'h0D;

endpackage

// File: rtl/message_sender.sv
// Reads one message from a registered-output RAM (addresses 0..MSG_LEN-1) and hands
// each byte to the UART transmitter using a new_tx_data / tx_busy handshake.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle request to send a full message (ignored unless idle)
//   addr         : RAM read address (registered)
//   data         : RAM read data, valid RD_LAT cycles after addr settles
//   tx_busy      : UART busy level, only looked at while waiting to hand off a byte
//   tx_data      : byte for the UART (registered)
//   new_tx_data  : one-cycle strobe qualifying tx_data
//   busy         : high from the cycle after start is accepted until the done cycle ends
//   done         : one-cycle pulse after the last byte has been handed off
module message_sender
  import msg_pkg::*;
#(
  parameter int unsigned MSG_LEN = MSG_LEN_DEFAULT,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned        LatW    = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [LatW-1:0]    LatLast = LatW'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0]  CntLast = ADDR_W'(MSG_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              new_tx_data_q, new_tx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lat_d         = lat_q;
    tx_data_d     = tx_data_q;
    new_tx_data_d = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          cnt_d   = '0;
          lat_d   = '0;
          busy_d  = 1'b1;
        end
      end

      // addr is the byte counter itself, so it is stable for the whole wait.
      StFetch: begin
        if (lat_q == LatLast) begin
          lat_d   = '0;
          state_d = StLoad;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      StLoad: begin
        if (!tx_busy) begin
          tx_data_d     = data;
          new_tx_data_d = 1'b1;
          state_d       = StHold;
        end
      end

      // Guard cycle: lets the UART raise tx_busy before the next LOAD samples it.
      StHold: begin
        if (cnt_q == CntLast) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StFetch;
        end
      end

      // start is deliberately not looked at here; restart is only accepted from idle.
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      lat_q         <= '0;
      tx_data_q     <= 8'h00;
      new_tx_data_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lat_q         <= lat_d;
      tx_data_q     <= tx_data_d;
      new_tx_data_q <= new_tx_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign addr        = cnt_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_data_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_message_sender.sv
module tb_message_sender;
  import msg_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, start3;
  logic       tx_busy, tx_busy3;
  logic [3:0] addr, addr3;
  logic [7:0] data, data3, tx_data, tx_data3;
  logic       new_tx_data, new_tx_data3, busy, busy3, done, done3;

  always #5 clk = ~clk;

  message_sender #(.MSG_LEN(10), .ADDR_W(4), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .data(data), .tx_busy(tx_busy),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .busy(busy), .done(done)
  );

  message_sender #(.MSG_LEN(10), .ADDR_W(4), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .addr(addr3), .data(data3), .tx_busy(tx_busy3),
    .tx_data(tx_data3), .new_tx_data(new_tx_data3), .busy(busy3), .done(done3)
  );

  // Message: "10110010\n\r"
  logic [7:0] exp_msg [10];
  logic [7:0] mem [16];
  initial begin
    exp_msg = '{8'h31, 8'h30, 8'h31, 8'h31, 8'h30, 8'h30, 8'h31, 8'h30, ASCII_LF, ASCII_CR};
    for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? exp_msg[i] : 8'h00;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: latency 1, and latency 3 returning X until addr has been stable long enough.
  logic [3:0] h1;
  logic [3:0] h3 [3];
  always @(posedge clk) begin
    h1    <= addr;
    h3[0] <= addr3;
    h3[1] <= h3[0];
    h3[2] <= h3[1];
  end
  assign data  = mem[h1];
  assign data3 = (h3[0] == h3[1] && h3[1] == h3[2]) ? mem[h3[0]] : 8'hxx;

  // UART busy model: rises the cycle after a strobe and stays high 20 cycles.
  logic bp_en;
  int   bp_cnt = 0;
  always @(posedge clk) begin
    if (bp_en && new_tx_data) bp_cnt <= 20;
    else if (bp_cnt > 0)      bp_cnt <= bp_cnt - 1;
  end
  assign tx_busy = (bp_cnt != 0);

  // Monitors
  logic [7:0] s_data [$];
  int         s_cyc  [$];
  int         s_addr [$];
  int         s_chg  [$];
  int         d_cyc  [$];
  int         b_rise [$];
  logic [7:0] t_data [$];
  int         t_cyc  [$];
  int         t_done;
  int         chg = 0;
  logic [3:0] addr_prev = 4'h0;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    if (addr !== addr_prev) chg++;
    addr_prev = addr;
    if (new_tx_data) begin
      s_data.push_back(tx_data);
      s_cyc.push_back(cyc);
      s_addr.push_back(int'(addr));
      s_chg.push_back(chg);
      chg = 0;
    end
    if (done) d_cyc.push_back(cyc);
    if (busy && !busy_prev) b_rise.push_back(cyc);
    busy_prev = busy;
    if (new_tx_data3) begin
      t_data.push_back(tx_data3);
      t_cyc.push_back(cyc);
    end
    if (done3) t_done++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_mon();
    s_data.delete(); s_cyc.delete(); s_addr.delete(); s_chg.delete();
    d_cyc.delete(); b_rise.delete();
  endtask

  task automatic wait_dones(input int n, input int limit);
    int k = 0;
    while (d_cyc.size() < n && k < limit) begin
      tick();
      k++;
    end
    chk("done_seen", d_cyc.size(), n);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_txd"},  tx_data, 8'h00);
    chk({tag, "_new"},  new_tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic chk_msg(input string tag, input int spacing);
    chk({tag, "_nstrobe"}, s_data.size(), 10);
    for (int i = 0; i < s_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), s_data[i], exp_msg[i % 10]);
      chk($sformatf("%s_addr%0d", tag, i), s_addr[i], i % 10);
      if (i > 0 && spacing > 0)
        chk($sformatf("%s_gap%0d", tag, i), s_cyc[i] - s_cyc[i-1], spacing);
    end
  endtask

  int st;

  initial begin
    rst = 1'b1; start = 1'b0; start3 = 1'b0; tx_busy3 = 1'b0; bp_en = 1'b0; t_done = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_reset_outs("rst");
    chk("rst3_busy", busy3, 0);

    // Basic send
    clear_mon();
    repeat (2) tick();
    st = cyc;
    pulse_start();
    wait_dones(1, 100);
    chk_msg("basic", 3);
    if (s_cyc.size() > 0) chk("basic_first", s_cyc[0] - st, 3);
    if (b_rise.size() > 0) chk("basic_busyrise", b_rise[0] - st, 1);
    if (d_cyc.size() > 0 && s_cyc.size() > 0) chk("basic_donepos", d_cyc[0] - s_cyc[$], 1);
    tick();
    chk("basic_idle_busy", busy, 0);

    // Backpressure
    clear_mon();
    bp_en = 1'b1;
    pulse_start();
    wait_dones(1, 400);
    chk_msg("bp", 22);
    for (int i = 1; i < s_chg.size(); i++)
      chk($sformatf("bp_addrchg%0d", i), s_chg[i], 1);
    bp_en = 1'b0;
    repeat (25) tick();

    // Latency 3 instance
    st = cyc;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    begin
      int k = 0;
      while (t_done < 1 && k < 200) begin tick(); k++; end
    end
    chk("lat3_done", t_done, 1);
    chk("lat3_nstrobe", t_data.size(), 10);
    if (t_cyc.size() > 0) chk("lat3_first", t_cyc[0] - st, 5);
    for (int i = 0; i < t_data.size(); i++) begin
      chk($sformatf("lat3_x%0d", i), $isunknown(t_data[i]), 0);
      chk($sformatf("lat3_data%0d", i), t_data[i], exp_msg[i]);
      if (i > 0) chk($sformatf("lat3_gap%0d", i), t_cyc[i] - t_cyc[i-1], 5);
    end

    // Start while busy, and start in the done cycle
    clear_mon();
    pulse_start();
    begin
      int k = 0;
      while (s_data.size() < 4 && k < 100) begin tick(); k++; end
    end
    chk("sb_busy_at4", busy, 1);
    pulse_start();
    begin
      int k = 0;
      while (!done && k < 100) begin tick(); k++; end
    end
    chk("sb_in_done", done, 1);
    pulse_start();
    repeat (10) tick();
    chk("sb_nstrobe", s_data.size(), 10);
    chk("sb_ndone", d_cyc.size(), 1);
    chk("sb_nbusyrise", b_rise.size(), 1);
    chk("sb_busy_after", busy, 0);

    // Reset during LOAD of byte 6
    clear_mon();
    pulse_start();
    begin
      int k = 0;
      while (s_data.size() < 5 && k < 100) begin tick(); k++; end
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outs("mid");
    repeat (10) tick();
    chk("mid_nstrobe", s_data.size(), 5);
    chk("mid_ndone", d_cyc.size(), 0);
    chk("mid_busy", busy, 0);
    clear_mon();
    pulse_start();
    wait_dones(1, 100);
    chk_msg("mid_restart", 3);

    // Back-to-back: restart the cycle after each done
    tick();
    clear_mon();
    pulse_start();
    for (int m = 0; m < 3; m++) begin
      int k = 0;
      while (!done && k < 100) begin tick(); k++; end
      chk($sformatf("b2b_done%0d", m), done, 1);
      tick();
      if (m < 2) pulse_start();
    end
    repeat (5) tick();
    chk("b2b_nstrobe", s_data.size(), 30);
    chk("b2b_ndone", d_cyc.size(), 3);
    for (int i = 0; i < s_data.size(); i++)
      chk($sformatf("b2b_data%0d", i), s_data[i], exp_msg[i % 10]);
    for (int i = 1; i < d_cyc.size(); i++)
      chk($sformatf("b2b_donegap%0d", i), d_cyc[i] - d_cyc[i-1], 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
